// File: rtl/hrglass_turn_sequencer_if.sv
// rtl/hrglass_turn_sequencer_if.sv - host-side program/start/result bundle for the turn sequencer
interface hrglass_turn_sequencer_if #(
    parameter int AW = 4,
    parameter int TW = 8
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [1:0]    prog_data;
    logic          start;
    logic [AW:0]   prog_len;
    logic          busy;
    logic          turn_small;
    logic          turn_large;
    logic [2:0]    event_dt;
    logic [TW-1:0] elapsed;
    logic          result_valid;
    logic          result_error;
    logic          result_ack;

    modport master (
        output prog_we, prog_addr, prog_data, start, prog_len, result_ack,
        input  busy, turn_small, turn_large, event_dt, elapsed, result_valid, result_error
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, prog_len, result_ack,
        output busy, turn_small, turn_large, event_dt, elapsed, result_valid, result_error
    );
endinterface

// File: rtl/hrglass_turn_sequencer.sv
// rtl/hrglass_turn_sequencer.sv - replays a turn program against a shadow model of two hourglasses
module hrglass_turn_sequencer #(
    parameter int SMALL = 4,
    parameter int LARGE = 7,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TW    = 8
) (
    input logic                     clk_i,
    input logic                     rst_i,
    hrglass_turn_sequencer_if.slave bus_if
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [2:0]  SMALL_L = 3'(SMALL);
    localparam logic [2:0]  LARGE_L = 3'(LARGE);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [2:0]    small_top_q, small_top_d;
    logic [2:0]    large_top_q, large_top_d;
    logic [2:0]    dt_q, dt_d;
    logic [TW-1:0] elapsed_q, elapsed_d;
    logic [AW-1:0] step_q, step_d;
    logic [AW:0]   len_q, len_d;
    logic          ts_q, ts_d, tl_q, tl_d, err_q, err_d;

    logic [1:0]    prog_mem [DEPTH];
    logic [1:0]    cur_bits;
    logic [2:0]    dt, small_adv, large_adv;
    logic [TW:0]   sum;
    logic          stall, ovf, len_bad, last_step;

    // Program RAM: host writes are dropped while a program is running so it cannot change underneath us
    always_ff @(posedge clk_i) begin
        if (bus_if.prog_we && state_q != S_RUN) begin
            prog_mem[bus_if.prog_addr] <= bus_if.prog_data;
        end
    end

    // State register; RAM contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            small_top_q <= 3'd0;
            large_top_q <= 3'd0;
            dt_q        <= 3'd0;
            elapsed_q   <= '0;
            step_q      <= '0;
            len_q       <= '0;
            ts_q        <= 1'b0;
            tl_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            small_top_q <= small_top_d;
            large_top_q <= large_top_d;
            dt_q        <= dt_d;
            elapsed_q   <= elapsed_d;
            step_q      <= step_d;
            len_q       <= len_d;
            ts_q        <= ts_d;
            tl_q        <= tl_d;
            err_q       <= err_d;
        end
    end

    // Step datapath and next-state logic: advance to the next glass emptying, then apply the step's turns
    always_comb begin
        cur_bits  = prog_mem[step_q];
        len_bad   = (bus_if.prog_len == '0) || (bus_if.prog_len > DEPTH_L);
        last_step = ({1'b0, step_q} == (len_q - (AW+1)'(1)));
        stall     = (step_q != '0) && (small_top_q == 3'd0) && (large_top_q == 3'd0);

        dt = 3'd0;
        if (step_q != '0) begin
            if (small_top_q == 3'd0)             dt = large_top_q;
            else if (large_top_q == 3'd0)        dt = small_top_q;
            else if (small_top_q < large_top_q)  dt = small_top_q;
            else                                 dt = large_top_q;
        end
        small_adv = (small_top_q != 3'd0) ? small_top_q - dt : 3'd0;
        large_adv = (large_top_q != 3'd0) ? large_top_q - dt : 3'd0;
        sum       = {1'b0, elapsed_q} + {{(TW-2){1'b0}}, dt};
        ovf       = sum[TW];

        state_d     = state_q;
        small_top_d = small_top_q;
        large_top_d = large_top_q;
        elapsed_d   = elapsed_q;
        step_d      = step_q;
        len_d       = len_q;
        err_d       = err_q;
        dt_d        = 3'd0;
        ts_d        = 1'b0;
        tl_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    step_d      = '0;
                    elapsed_d   = '0;
                    small_top_d = 3'd0;
                    large_top_d = 3'd0;
                    err_d       = len_bad;
                    len_d       = bus_if.prog_len;
                    state_d     = len_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (stall) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ovf) begin
                    elapsed_d   = '1;
                    small_top_d = small_adv;
                    large_top_d = large_adv;
                    dt_d        = dt;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    elapsed_d   = sum[TW-1:0];
                    small_top_d = cur_bits[1] ? SMALL_L - small_adv : small_adv;
                    large_top_d = cur_bits[0] ? LARGE_L - large_adv : large_adv;
                    ts_d        = cur_bits[1];
                    tl_d        = cur_bits[0];
                    dt_d        = dt;
                    if (last_step) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                if (bus_if.result_ack) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.busy         = (state_q != S_IDLE);
    assign bus_if.turn_small   = ts_q;
    assign bus_if.turn_large   = tl_q;
    assign bus_if.event_dt     = dt_q;
    assign bus_if.elapsed      = elapsed_q;
    assign bus_if.result_valid = (state_q == S_DONE);
    assign bus_if.result_error = err_q && (state_q == S_DONE);

    // Shadow sand can never exceed the glass capacity
    assert property (@(posedge clk_i) disable iff (rst_i)
        (small_top_q <= SMALL_L) && (large_top_q <= LARGE_L));
endmodule
